// File: rtl/eth_tx_frame_arb.sv
// Transmit frame arbiter: merges NUM_CH whole-frame sources onto one tx data/length FIFO pair.
// Runt frames are zero-padded to MIN_LEN; empty or oversize frames are drained and dropped.
module eth_tx_frame_arb #(
    parameter int NUM_CH  = 4,
    parameter int DW      = 8,
    parameter int LW      = 16,
    parameter int RR_MODE = 1,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518
) (
    input  logic                 clk_i,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*LW-1:0] ch_len,
    input  logic [NUM_CH*DW-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_rd,
    output logic [NUM_CH-1:0]    ch_done,
    output logic [DW-1:0]        tx_data_fifo_data,
    output logic                 tx_data_fifo_write,
    output logic [LW-1:0]        tx_len_fifo_data,
    output logic                 tx_len_fifo_write,
    input  logic                 tx_data_fifo_afull,
    input  logic                 tx_len_fifo_full,
    output logic                 busy,
    output logic [15:0]          drop_cnt
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LW-1:0] MIN_L   = LW'(MIN_LEN);
    localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAD,
        S_DROP,
        S_COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] grant_q, grant_d;
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] arb_idx;
    logic          arb_found;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] arb_len;
    logic [DW-1:0] grant_data;
    logic          issue_data;
    logic          issue_pad;
    logic          commit;
    logic          drop_done;

    // Round-robin searches upward from ptr with wrap; fixed priority searches from index 0.
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (RR_MODE != 0) ? int'(ptr_q) + i : i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!arb_found && ch_req[CW'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = CW'(cand);
            end
        end
    end

    assign arb_len    = ch_len[arb_idx*LW +: LW];
    assign grant_data = ch_data[grant_q*DW +: DW];
    assign busy       = (state_q != S_IDLE);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ch_rd      = '0;
        ch_done    = '0;
        issue_data = 1'b0;
        issue_pad  = 1'b0;
        commit     = 1'b0;
        drop_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_found && !tx_len_fifo_full) begin
                    grant_d = arb_idx;
                    len_d   = arb_len;
                    cnt_d   = '0;
                    if (arb_len == '0 || arb_len > MAX_L) state_d = S_DROP;
                    else                                  state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (!tx_data_fifo_afull) begin
                    ch_rd[grant_q] = 1'b1;
                    issue_data     = 1'b1;
                    cnt_d          = cnt_q + ONE_L;
                    if (cnt_q == len_q - ONE_L)
                        state_d = (len_q < MIN_L) ? S_PAD : S_COMMIT;
                end
            end

            S_PAD: begin
                if (!tx_data_fifo_afull) begin
                    issue_pad = 1'b1;
                    cnt_d     = cnt_q + ONE_L;
                    if (cnt_q == MIN_L - ONE_L) state_d = S_COMMIT;
                end
            end

            // Drain the rejected frame from the source regardless of downstream backpressure.
            S_DROP: begin
                if (len_q != '0) begin
                    ch_rd[grant_q] = 1'b1;
                    cnt_d          = cnt_q + ONE_L;
                end
                if (len_q == '0 || cnt_q == len_q - ONE_L) begin
                    drop_done        = 1'b1;
                    ch_done[grant_q] = 1'b1;
                    state_d          = S_IDLE;
                end
            end

            S_COMMIT: begin
                if (!tx_len_fifo_full) begin
                    commit           = 1'b1;
                    ch_done[grant_q] = 1'b1;
                    state_d          = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q              <= '0;
            drop_cnt           <= '0;
            tx_data_fifo_data  <= '0;
            tx_data_fifo_write <= 1'b0;
            tx_len_fifo_data   <= '0;
            tx_len_fifo_write  <= 1'b0;
        end else begin
            tx_data_fifo_write <= issue_data | issue_pad;
            if (issue_data)     tx_data_fifo_data <= grant_data;
            else if (issue_pad) tx_data_fifo_data <= '0;

            tx_len_fifo_write <= commit;
            if (commit) tx_len_fifo_data <= (len_q < MIN_L) ? MIN_L : len_q;

            if (drop_done && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

            if (commit || drop_done)
                ptr_q <= (grant_q == LAST_CH) ? '0 : grant_q + CW'(1);
        end
    end

endmodule

// File: doc/eth_tx_frame_arb.md
# eth_tx_frame_arb

Multi-channel transmit frame arbiter. It merges NUM_CH independent frame sources onto the single tx length/data FIFO write interface that feeds the tx FIFO wrapper and the MAC. Frames are granted whole, in round-robin or fixed-priority order. The block pads runt frames to MIN_LEN, discards zero-length or oversize frames, and writes the length word only after the last data byte, so a frame is committed atomically.

## Interface
- NUM_CH, 4: number of source channels (1..16).
- DW, 8: data byte width.
- LW, 16: length word width.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.
- MIN_LEN, 60: minimum frame length in bytes; shorter frames are zero-padded.
- MAX_LEN, 1518: maximum legal length; longer frames are dropped.

- clk_i  in  1: system clock. All logic is on this single clock.
- reset_n  in  1: reset, asynchronous, active-low.
- ch_req  in  NUM_CH: channel i has a complete frame queued. Held until ch_done[i].
- ch_len  in  NUM_CH*LW: frame length of channel i, slice [i*LW +: LW]. Stable while ch_req[i]=1.
- ch_data  in  NUM_CH*DW: head byte of channel i, first-word-fall-through.
- ch_rd  out  NUM_CH: pops one byte from channel i. Combinational from state.
- ch_done  out  NUM_CH: one-cycle pulse when channel i's frame is committed or dropped.
- tx_data_fifo_data  out  DW: registered data byte.
- tx_data_fifo_write  out  1: registered data write strobe.
- tx_len_fifo_data  out  LW: registered committed length (padded).
- tx_len_fifo_write  out  1: registered length write strobe.
- tx_data_fifo_afull  in  1: data FIFO almost full. Stalls byte issue.
- tx_len_fifo_full  in  1: length FIFO full.
- busy  out  1: state is not IDLE.
- drop_cnt  out  16: count of dropped frames, saturating at 0xFFFF.

## Operation
- States: IDLE, DATA, PAD, DROP, COMMIT.
- IDLE: if any ch_req=1 and tx_len_fifo_full=0:
  - Select grant g. With RR_MODE=1, search starts at pointer ptr (wrapping to 0 after NUM_CH-1). With RR_MODE=0, the lowest set index wins.
  - Latch L = ch_len[g] and clear the byte counter cnt (LW bits).
  - If L==0 or L>MAX_LEN, go to DROP; otherwise go to DATA.
- DATA: each cycle with afull=0, assert ch_rd[g]. The next cycle registers tx_data_fifo_data=ch_data[g] with write=1. cnt increments per byte issued.
  - After the byte at cnt==L-1: go to PAD if L<MIN_LEN, else go to COMMIT.
  - afull=1 issues nothing and holds cnt.
- PAD: each cycle with afull=0, write 0x00 and increment cnt. After cnt==MIN_LEN-1, go to COMMIT.
- DROP: assert ch_rd[g] for L cycles (0 cycles when L==0), ignoring afull. No tx writes. Increment drop_cnt (saturating), pulse ch_done[g], update ptr, return to IDLE.
- COMMIT: wait while tx_len_fifo_full=1. Otherwise, the next cycle registers tx_len_fifo_data=max(L,MIN_LEN) with write=1. Pulse ch_done[g], set ptr=(g+1) mod NUM_CH, return to IDLE.
- ptr updates only on ch_done; its reset value is 0.
- A ch_req change for a channel other than g has no effect on the frame in progress.
- Length arithmetic and comparisons are unsigned LW-bit. MIN_LEN and MAX_LEN must be less than 2^LW.

## Timing
- Reset values:
  - All outputs 0: tx_*_data, tx_*_write, ch_rd, ch_done, busy, drop_cnt.
  - State IDLE, ptr 0, cnt 0.
- Reset assertion mid-frame aborts immediately. No length is written, and the partial data already written is the source's responsibility.
- The grant is decided in the IDLE cycle. The first ch_rd occurs in the following cycle, the first tx data write one cycle after that.
- Unstalled throughput is 1 byte per cycle. Total frame occupancy is max(L,MIN_LEN)+3 cycles from the IDLE grant cycle to the cycle after the ch_done pulse.
- The tx_len_fifo_write pulse comes 1 cycle after the last data write, or later if the length FIFO is full.
- The ch_done pulse coincides with the COMMIT exit cycle.
- afull is sampled in the same cycle as the ch_rd decision. Downstream must absorb 1 in-flight byte after asserting afull.

## Test plan
- Single frame: ch_req=0001, L=100, data 0..99, no stall. Required response:
  - 100 data writes with matching bytes.
  - Length write 100, one cycle after the last byte.
  - ch_done[0] pulse; busy low afterwards.
- Round-robin: channels 0, 1 and 3 all request with L=64. Required grant order is 0, 1, 3, then 0 again on re-request; no bytes interleave between frames. With RR_MODE=0 and channels 0 and 1 requesting continuously, channel 0 wins every time.
- Padding: L=10 with bytes 0xA1.. → 10 source bytes, then 50 bytes of 0x00, length write 60.
- Drop: L=2000 → 2000 ch_rd pulses, no tx writes, drop_cnt=1, ch_done pulse. L=0 → no ch_rd, drop_cnt=2.
- Backpressure:
  - afull toggled every 3 cycles during L=200 → exactly 200 bytes, in order, with no duplicates.
  - tx_len_fifo_full held for 5 cycles at COMMIT → length written on the cycle after full deasserts.
- Reset mid-frame: assert reset_n=0 at byte 30 of L=100 → all outputs 0 immediately, no length write. After release, a new frame proceeds normally from ptr=0.
